// File: rtl/i2_router_out_arbiter_pkg.sv
// Shared definitions for the router output arbiter and the per-port FIFO write controllers:
// flit-type codes, arbiter state encoding and the select-width derivation.
package i2_router_out_arbiter_pkg;

    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b110;
    localparam logic [2:0] FLIT_TAIL = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Width of an index into n items; never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i, with wrap-around.
// The request at ptr_i itself is checked last, so the previous winner has lowest priority.
module i2_rr_pick
    import i2_router_out_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = sel_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [W-1:0] cand_idx;

    // NOTE: every always_comb output gets a default before any branch; a path that leaves a
    // variable unassigned would otherwise infer a latch.
    always_comb begin
        idx_o    = '0;
        found_o  = 1'b0;
        cand_idx = '0;
        for (int off = 1; off <= N; off++) begin
            cand_idx = W'((int'(ptr_i) + off) % N);
            if (!found_o && req_i[cand_idx]) begin
                found_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/i2_router_out_arbiter.sv
// Packet-granular round-robin arbiter for one router output link: a FIFO wins on a HEAD flit
// and keeps the link until its TAIL is read, so packets never interleave.
module i2_router_out_arbiter
    import i2_router_out_arbiter_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int MAX_FLITS = 16,
    parameter int SEL_W     = sel_width(NUM_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IN-1:0]     fifo_empty,
    input  logic [3*NUM_IN-1:0]   fifo_type,
    input  logic                  out_busy,
    output logic [NUM_IN-1:0]     fifo_rd,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    output logic                  err_malformed
);

    localparam int                CNT_W    = sel_width(MAX_FLITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_FLITS - 1);

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
    logic               err_q, err_d;

    logic [NUM_IN-1:0]  cand;
    logic [2:0]         type_arr [NUM_IN];
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic [2:0]         gnt_type;
    logic               rd_en;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_front
        assign type_arr[g] = fifo_type[3*g +: 3];
        assign cand[g]     = !fifo_empty[g] && (fifo_type[3*g +: 3] == FLIT_HEAD);
    end

    i2_rr_pick #(
        .N (NUM_IN),
        .W (SEL_W)
    ) u_rr_pick (
        .req_i   (cand),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign gnt_type      = type_arr[gnt_idx_q];
    assign rd_en         = (state_q == ST_XFER) && !fifo_empty[gnt_idx_q] && !out_busy;
    assign out_sel       = gnt_idx_q;
    assign err_malformed = err_q;

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        flit_cnt_d = flit_cnt_q;
        err_d      = err_q;
        fifo_rd    = '0;
        out_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found && !out_busy) begin
                    gnt_idx_d  = pick_idx;
                    flit_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (rd_en) begin
                    fifo_rd[gnt_idx_q] = 1'b1;
                    out_valid          = 1'b1;
                    flit_cnt_d         = flit_cnt_q + 1'b1;
                    // A HEAD after the first read is forwarded as BODY but flagged.
                    if (gnt_type == FLIT_HEAD && flit_cnt_q != '0) begin
                        err_d = 1'b1;
                    end
                    if (gnt_type == FLIT_TAIL) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = gnt_idx_q;
                    end else if (flit_cnt_q == CNT_LAST) begin
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                        rr_ptr_d = gnt_idx_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= SEL_W'(NUM_IN - 1);
            flit_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_cnt_q <= flit_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule
